// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU stage modules and the memory port arbiter.
package cpu_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE = 32'h1000_0000;
    localparam logic [31:0] IO_BASE  = 32'h2000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_counter.sv
// Small saturating up-counter with synchronous clear; clear wins over increment.
module arb_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != MAX_V)) begin
            count_next = count_reg + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory port between instruction fetch and the load/store path,
// with data priority, a fetch starvation bound and a per-transaction timeout.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = WORD_ADDR_W,
    parameter int DATA_W     = WORD_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    arb_state_t        state_reg, state_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              i_ack_reg, i_ack_next;
    logic              d_ack_reg, d_ack_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

    logic       starve_clr, starve_inc;
    logic       to_clr, to_inc;
    logic [3:0] starve_cnt;
    logic [7:0] to_cnt;

    logic              cand_i, cand_d;
    logic              timeout_hit;
    logic [DATA_W-1:0] done_rdata;

    arb_counter #(.WIDTH(4), .MAX(STARVE_MAX)) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (starve_clr),
        .inc   (starve_inc),
        .count (starve_cnt)
    );

    arb_counter #(.WIDTH(8), .MAX(255)) u_to_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (to_clr),
        .inc   (to_inc),
        .count (to_cnt)
    );

    // A requester in its ack cycle is still holding req for the finished transaction.
    assign cand_i      = i_req && !i_ack_reg;
    assign cand_d      = d_req && !d_ack_reg;
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign done_rdata  = mem_we_reg ? '0 : mem_rdata;

    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        i_ack_next     = 1'b0;
        d_ack_next     = 1'b0;
        err_next       = 1'b0;
        starve_clr     = 1'b0;
        starve_inc     = 1'b0;
        to_clr         = 1'b0;
        to_inc         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cand_d && (!cand_i || (starve_cnt < STARVE_LIM))) begin
                    state_next     = BUSY_D;
                    mem_req_next   = 1'b1;
                    mem_we_next    = d_we;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                    to_clr         = 1'b1;
                    starve_inc     = i_req;
                    starve_clr     = !i_req;
                end else if (cand_i) begin
                    state_next     = BUSY_I;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = i_addr;
                    mem_wdata_next = '0;
                    to_clr         = 1'b1;
                    starve_clr     = 1'b1;
                end
            end

            BUSY_I, BUSY_D: begin
                // mem_ack wins over a timeout landing in the same cycle.
                if (mem_ack || timeout_hit) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    err_next     = !mem_ack;
                    if (state_reg == BUSY_I) begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = mem_ack ? done_rdata : '0;
                    end else begin
                        d_ack_next   = 1'b1;
                        d_rdata_next = mem_ack ? done_rdata : '0;
                    end
                end else begin
                    to_inc = 1'b1;
                end
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            err_reg       <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            i_ack_reg     <= i_ack_next;
            d_ack_reg     <= d_ack_next;
            err_reg       <= err_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign i_ack     = i_ack_reg;
    assign d_ack     = d_ack_reg;
    assign err       = err_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule
